freq_meter_core: RTL and testbench

//  Parametrised equal-precision (reciprocal) frequency meter core; successor to the 32-bit gated counter pair.

---
 rtl/freq_meter_pkg.sv | 14 +
 rtl/freq_meter_core_sync.sv | 35 +++
 rtl/freq_meter_core.sv | 163 ++++++++++++++++
 tb/tb_freq_meter_core.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared types and defaults for the reciprocal frequency meter.
// Optional duty-cycle counter is enabled with FREQ_DUTY_EN.
package freq_meter_pkg;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    GATE
  } state_e;

endpackage

// File: rtl/freq_meter_core_sync.sv
// sig_edge_sync: SIG_IN synchroniser chain plus one-cycle rising-edge pulse.
// FREQ_DUTY_EN exposes the synchronised level for the duty-cycle counter.
module sig_edge_sync
  import freq_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic CLK,
  input  logic CLR,
  input  logic sig_i,
`ifdef FREQ_DUTY_EN
  output logic sync_o,
`endif
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   prev_q;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], sig_i};
      prev_q  <= chain_q[SYNC_STAGES-1];
    end
  end

`ifdef FREQ_DUTY_EN
  assign sync_o = chain_q[SYNC_STAGES-1];
`endif
  assign rise_o = chain_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meter_core.sv
// freq_meter_core: equal-precision meter, gate opened and closed on SIG_IN rises.
// Define FREQ_DUTY_EN to add the CNT_HIGH duty-cycle counter and port.
module freq_meter_core
  import freq_meter_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             START,
  input  logic [WIDTH-1:0] GATE_TICKS,
  input  logic             SIG_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] CNT_SIG,
  output logic [WIDTH-1:0] CNT_BASE,
  output logic             OVF
`ifdef FREQ_DUTY_EN
  ,
  output logic [WIDTH-1:0] CNT_HIGH
`endif
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] timer_q, timer_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [WIDTH-1:0] cnt_sig_q, cnt_sig_d;
  logic [WIDTH-1:0] cnt_base_q, cnt_base_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             rise, close, sat;
`ifdef FREQ_DUTY_EN
  logic             sync;
  logic [WIDTH-1:0] high_q, high_d;
  logic [WIDTH-1:0] cnt_high_q, cnt_high_d;
`endif

  sig_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK    (CLK),
    .CLR    (CLR),
    .sig_i  (SIG_IN),
`ifdef FREQ_DUTY_EN
    .sync_o (sync),
`endif
    .rise_o (rise)
  );

  // Timer at 1 closes too: it reaches 0 in this same cycle.
  assign close = (state_q == GATE) && rise && (timer_q <= ONE);
  assign sat   = (state_q != IDLE) && (base_q == '1) && !close;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      base_q     <= '0;
      sig_q      <= '0;
      cnt_sig_q  <= '0;
      cnt_base_q <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef FREQ_DUTY_EN
      high_q     <= '0;
      cnt_high_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      base_q     <= base_d;
      sig_q      <= sig_d;
      cnt_sig_q  <= cnt_sig_d;
      cnt_base_q <= cnt_base_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
`ifdef FREQ_DUTY_EN
      high_q     <= high_d;
      cnt_high_q <= cnt_high_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    base_d     = base_q;
    sig_d      = sig_q;
    cnt_sig_d  = cnt_sig_q;
    cnt_base_d = cnt_base_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
`ifdef FREQ_DUTY_EN
    high_d     = high_q;
    cnt_high_d = cnt_high_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d = ARM;
          timer_d = GATE_TICKS;
          base_d  = '0;
        end
      end
      ARM: begin
        base_d = base_q + ONE;
        if (rise) begin
          state_d = GATE;
          sig_d   = '0;
          base_d  = '0;
`ifdef FREQ_DUTY_EN
          high_d  = '0;
`endif
        end
      end
      GATE: begin
        base_d = base_q + ONE;
        if (timer_q != '0) timer_d = timer_q - ONE;
        if (rise) sig_d = sig_q + ONE;
`ifdef FREQ_DUTY_EN
        high_d = high_q + WIDTH'(sync);
`endif
      end
      default: state_d = IDLE;
    endcase
    if (close) begin
      state_d    = IDLE;
      done_d     = 1'b1;
      cnt_sig_d  = sig_q + ONE;
      cnt_base_d = base_q + ONE;
      ovf_d      = 1'b0;
`ifdef FREQ_DUTY_EN
      cnt_high_d = high_q + WIDTH'(sync);
`endif
    end else if (sat) begin
      state_d    = IDLE;
      done_d     = 1'b1;
      cnt_sig_d  = '0;
      cnt_base_d = '0;
      ovf_d      = 1'b1;
`ifdef FREQ_DUTY_EN
      cnt_high_d = '0;
`endif
    end
  end

  always_comb begin
    BUSY = (state_q != IDLE);
  end

  assign DONE     = done_q;
  assign CNT_SIG  = cnt_sig_q;
  assign CNT_BASE = cnt_base_q;
  assign OVF      = ovf_q;
`ifdef FREQ_DUTY_EN
  assign CNT_HIGH = cnt_high_q;
`endif

endmodule

// File: tb/tb_freq_meter_core.sv
// tb_freq_meter_core: directed and randomized checks of freq_meter_core.
// Duty-cycle checks are compiled in when FREQ_DUTY_EN is defined.
module tb_freq_meter_core;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        START = 1'b0;
  logic [31:0] GATE_TICKS = '0;
  logic        SIG_IN = 1'b0;
  logic        BUSY, DONE, OVF;
  logic [31:0] CNT_SIG, CNT_BASE;

  logic        START8 = 1'b0;
  logic [7:0]  G8 = '0;
  logic        SIG8 = 1'b0;
  logic        BUSY8, DONE8, OVF8;
  logic [7:0]  CNT_SIG8, CNT_BASE8;
`ifdef FREQ_DUTY_EN
  logic [31:0] CNT_HIGH;
  logic [7:0]  CNT_HIGH8;
`endif

  int checks = 0;
  int errors = 0;
  bit wave[$];

  always #5 CLK = ~CLK;

  freq_meter_core u_dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .START      (START),
    .GATE_TICKS (GATE_TICKS),
    .SIG_IN     (SIG_IN),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .CNT_SIG    (CNT_SIG),
    .CNT_BASE   (CNT_BASE),
    .OVF        (OVF)
`ifdef FREQ_DUTY_EN
    ,
    .CNT_HIGH   (CNT_HIGH)
`endif
  );

  freq_meter_core #(.WIDTH(8)) u_w8 (
    .CLK        (CLK),
    .CLR        (CLR),
    .START      (START8),
    .GATE_TICKS (G8),
    .SIG_IN     (SIG8),
    .BUSY       (BUSY8),
    .DONE       (DONE8),
    .CNT_SIG    (CNT_SIG8),
    .CNT_BASE   (CNT_BASE8),
    .OVF        (OVF8)
`ifdef FREQ_DUTY_EN
    ,
    .CNT_HIGH   (CNT_HIGH8)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: gate opens on the first SIG rise after START, closes on the
  // first later rise at least max(g,1) cycles after the opening rise.
  function automatic void model(input int g, output bit found,
                                output int eb, output int es,
                                output int eh);
    int r0 = -1;
    int gm = (g < 1) ? 1 : g;
    found = 0; eb = 0; es = 0; eh = 0;
    for (int n = 1; n < wave.size() && !found; n++) begin
      if (wave[n] && !wave[n-1]) begin
        if (r0 < 0) r0 = n;
        else begin
          es++;
          if (n - r0 >= gm) begin
            found = 1;
            eb = n - r0;
          end
        end
      end
    end
    if (found)
      for (int n = r0 + 1; n <= r0 + eb; n++) eh += int'(wave[n]);
  endfunction

  task automatic lead_in();
    wave.delete();
    repeat (5) wave.push_back(1'b0);
  endtask

  task automatic periodic(input int p, input int h, input int len);
    lead_in();
    for (int n = 0; n < len; n++) wave.push_back((n % p) < h);
  endtask

  task automatic finish_wave(input int g);
    bit f; int b, s, h;
    model(g, f, b, s, h);
    while (!f) begin
      wave.push_back(1'b0);
      wave.push_back(1'b1);
      model(g, f, b, s, h);
    end
    repeat (12) wave.push_back(1'b0);
  endtask

  task automatic run(input string tag, input int g, input int xstart,
                     input int clr_at, input int exp_done);
    bit f; int eb, es, eh, nd;
    logic [31:0] cs, cb, ch; logic co;
    model(g, f, eb, es, eh);
    nd = 0; cs = '0; cb = '0; ch = '0; co = 1'bx;
    for (int i = 0; i < wave.size(); i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) begin
        nd++;
        cs = CNT_SIG; cb = CNT_BASE; co = OVF;
`ifdef FREQ_DUTY_EN
        ch = CNT_HIGH;
`endif
      end
      SIG_IN = wave[i];
      START = (i == 2) || (i == xstart);
      GATE_TICKS = (i == 2) ? g : $urandom;
      if (i == clr_at) begin
        CLR = 1'b0;
        #1;
        chk({tag, "_clr_busy"}, BUSY, 0);
        chk({tag, "_clr_sig"}, CNT_SIG, 0);
        chk({tag, "_clr_base"}, CNT_BASE, 0);
        chk({tag, "_clr_ovf"}, OVF, 0);
      end
      if (i == clr_at + 3) CLR = 1'b1;
    end
    START = 1'b0;
    chk({tag, "_ndone"}, nd, exp_done);
    if (exp_done == 1) begin
      chk({tag, "_sig"}, cs, es);
      chk({tag, "_base"}, cb, eb);
      chk({tag, "_ovf"}, co, 0);
      chk({tag, "_held"}, CNT_BASE, eb);
      chk({tag, "_busy"}, BUSY, 0);
`ifdef FREQ_DUTY_EN
      chk({tag, "_high"}, ch, eh);
`endif
    end
  endtask

  initial begin
    int p, h, g, n;
    #1;
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_ovf", OVF, 0);
    chk("rst_sig", CNT_SIG, 0);
    chk("rst_base", CNT_BASE, 0);
`ifdef FREQ_DUTY_EN
    chk("rst_high", CNT_HIGH, 0);
`endif
    repeat (2) @(negedge CLK);
    CLR = 1'b1;
    repeat (2) @(negedge CLK);

    periodic(10, 3, 110);
    finish_wave(95);
    run("p10_g95", 95, -1, -1, 1);
    chk("p10_g95_sig_lit", CNT_SIG, 10);
    chk("p10_g95_base_lit", CNT_BASE, 100);
`ifdef FREQ_DUTY_EN
    chk("p10_g95_high_lit", CNT_HIGH, 30);
`endif

    periodic(10, 3, 40);
    finish_wave(0);
    run("p10_g0", 0, -1, -1, 1);
    chk("p10_g0_sig_lit", CNT_SIG, 1);
    chk("p10_g0_base_lit", CNT_BASE, 10);

    periodic(10, 3, 110);
    finish_wave(95);
    run("start_in_gate", 95, 40, -1, 1);
    chk("start_in_gate_base_lit", CNT_BASE, 100);

    periodic(10, 3, 110);
    finish_wave(95);
    run("clr_mid", 95, -1, 40, 0);

    periodic(10, 3, 110);
    finish_wave(95);
    run("after_clr", 95, -1, -1, 1);
    chk("after_clr_sig_lit", CNT_SIG, 10);

    lead_in();
    n = 0;
    while (wave.size() < 1040) begin
      p = (n % 2 == 0) ? 7 : 8;
      for (int k = 0; k < p; k++) wave.push_back(k < 3);
      n++;
    end
    finish_wave(1000);
    run("alt78", 1000, -1, -1, 1);

    for (int t = 0; t < 4; t++) begin
      p = $urandom_range(3, 20);
      h = $urandom_range(1, p - 1);
      g = $urandom_range(0, 200);
      periodic(p, h, g + 3 * p);
      finish_wave(g);
      run("rnd_per", g, -1, -1, 1);
    end

    for (int t = 0; t < 2; t++) begin
      g = $urandom_range(0, 150);
      lead_in();
      for (int k = 0; k < g + 40; k++) wave.push_back(1'($urandom_range(0, 1)));
      finish_wave(g);
      run("rnd_bits", g, -1, -1, 1);
    end

    @(negedge CLK);
    START8 = 1'b1;
    G8 = 8'd5;
    @(negedge CLK);
    START8 = 1'b0;
    n = 1;
    chk("w8_busy", BUSY8, 1);
    while (DONE8 !== 1'b1 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    chk("w8_latency", n - 1, 256);
    chk("w8_ovf", OVF8, 1);
    chk("w8_sig", CNT_SIG8, 0);
    chk("w8_base", CNT_BASE8, 0);
    chk("w8_busy_drop", BUSY8, 0);
    @(negedge CLK);
    chk("w8_done_pulse", DONE8, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
